// File: rtl/display_pkg.sv
// Segment constants shared by every 7-segment display block.
// Encodings are active-low {g,f,e,d,c,b,a}.
package display_pkg;

  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Packed array, so the leftmost literal is index 15 (digit F)
  localparam logic [15:0][6:0] SEG_DIG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    return SEG_DIG[nib];
  endfunction

endpackage

// File: rtl/decod_hex7.sv
// Combinational hex nibble to active-low 7-segment decoder.
module decod_hex7
  import display_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = hex7(i_nib);

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed signed hex display driver with frame-synchronous load
// commit, leading-zero blanking and one dead-time clock per digit slot.
module display_mux
  import display_pkg::*;
#(
  parameter int DIGITOS       = 4,
  parameter int DIV_VARREDURA = 50000,
  parameter int SUPRIME_ZEROS = 1
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Carregar,
  input  logic [4*(DIGITOS-1)-1:0]   Valor,
  input  logic                       Negativo,
  output logic [6:0]                 Hex,
  output logic [DIGITOS-1:0]         Anodo,
  output logic                       Pronto
);

  localparam int MAG = DIGITOS - 1;
  localparam int VW  = 4 * MAG;
  localparam int IW  = $clog2(DIGITOS);
  localparam int CW  = $clog2(DIV_VARREDURA);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_VARREDURA - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITOS - 1);

  logic [CW-1:0]      r_cnt;
  logic [IW-1:0]      r_idx;
  logic [VW-1:0]      r_pval;
  logic               r_pneg;
  logic               r_pend;
  logic [VW-1:0]      r_cval;
  logic               r_cneg;
  logic [6:0]         r_hex;
  logic [DIGITOS-1:0] r_an;

  logic               w_tick;
  logic               w_wrap;
  logic               w_commit;
  logic [IW-1:0]      w_idx_nxt;
  logic [VW-1:0]      w_cval_nxt;
  logic               w_cneg_nxt;
  logic [MAG-1:0]     w_blk;
  logic               w_zero;
  logic [3:0]         w_nib;
  logic               w_blank_sel;
  logic [6:0]         w_dec;
  logic [6:0]         w_hex_nxt;

  assign w_tick    = (r_cnt == CNT_LAST);
  assign w_wrap    = w_tick && (r_idx == IDX_LAST);
  assign w_commit  = w_wrap && r_pend;
  assign w_idx_nxt = !w_tick ? r_idx :
                     (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

  // Segments are built from the value that will be committed at this edge,
  // so the first digit of a new frame already shows the new value.
  assign w_cval_nxt = w_commit ? r_pval : r_cval;
  assign w_cneg_nxt = w_commit ? r_pneg : r_cneg;

  always_comb begin
    w_zero      = 1'b1;
    w_blk       = '0;
    w_nib       = '0;
    w_blank_sel = 1'b0;
    for (int p = MAG - 1; p >= 0; p--) begin
      w_zero   = w_zero && (w_cval_nxt[4*p +: 4] == 4'h0);
      w_blk[p] = (SUPRIME_ZEROS == 1) && w_zero && (p != 0);
    end
    for (int p = 0; p < MAG; p++) begin
      if (w_idx_nxt == IW'(p)) begin
        w_nib       = w_cval_nxt[4*p +: 4];
        w_blank_sel = w_blk[p];
      end
    end
  end

  decod_hex7 u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  assign w_hex_nxt = (w_idx_nxt == IDX_LAST) ? (w_cneg_nxt ? SEG_MINUS : SEG_BLANK) :
                     w_blank_sel ? SEG_BLANK : w_dec;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_pval <= '0;
      r_pneg <= 1'b0;
      r_pend <= 1'b0;
      r_cval <= '0;
      r_cneg <= 1'b0;
      r_hex  <= SEG_BLANK;
      r_an   <= '1;
    end else begin
      r_cnt  <= w_tick ? '0 : r_cnt + 1'b1;
      r_idx  <= w_idx_nxt;
      r_cval <= w_cval_nxt;
      r_cneg <= w_cneg_nxt;
      if (Carregar) begin
        r_pval <= Valor;
        r_pneg <= Negativo;
        r_pend <= 1'b1;
      end else if (w_commit) begin
        r_pend <= 1'b0;
      end
      r_hex <= w_hex_nxt;
      // Dead time: all digits off for the clock after each tick
      r_an  <= w_tick ? '1 : ~(DIGITOS'(1) << r_idx);
    end
  end

  assign Hex    = r_hex;
  assign Anodo  = r_an;
  assign Pronto = ~r_pend;

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 SHALL have parameter DIGITOS, default 4, meaning the number of 7-segment positions, range 2..8.
REQ-002 SHALL have parameter DIV_VARREDURA, default 50000, meaning clocks per digit slot, minimum 2.
REQ-003 SHALL have parameter SUPRIME_ZEROS, default 1, meaning leading-zero blanking is enabled when set to 1.
REQ-004 SHALL have port Clock, input, 1 bit, the single clock; all logic uses the rising edge.
REQ-005 SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port Carregar, input, 1 bit, a load strobe sampled on each edge.
REQ-007 SHALL have port Valor, input, 4*(DIGITOS-1) bits, the hex magnitude (nibble 0 is the rightmost digit).
REQ-008 SHALL have port Negativo, input, 1 bit, the sign flag captured with Valor.
REQ-009 SHALL have port Hex, output, 7 bits, the active-low segments {g,f,e,d,c,b,a} (registered).
REQ-010 SHALL have port Anodo, output, DIGITOS bits, active-low one-hot digit enables (registered).
REQ-011 SHALL have port Pronto, output, 1 bit, where 1 means no load is pending and the last load is on the display.

Function
REQ-012 SHALL drive the digit encoding on Hex as follows: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18, A=08, B=03, C=46, D=21, E=06, F=0E, minus=3F, blank=7F (hex).
REQ-013 SHALL run a prescaler counting 0..DIV_VARREDURA-1, wrapping to 0; a "tick" is the cycle the count equals DIV_VARREDURA-1.
REQ-014 SHALL advance the digit index 0..DIGITOS-1 on each tick, wrapping DIGITOS-1 to 0; a "frame wrap" is a tick while the index equals DIGITOS-1.
REQ-015 SHALL register Hex and Anodo so they reflect the index with 1-clock latency; Anodo bit i=0 selects position i.
REQ-016 SHALL drive Anodo all-ones for exactly the one clock following each tick (dead time), with Hex already updated in that cycle.
REQ-017 SHALL display positions 0..DIGITOS-2 from the committed magnitude nibbles.
REQ-018 SHALL display position DIGITOS-1 as the sign slot: minus if committed Negativo=1, otherwise blank.
REQ-019 SHALL, when SUPRIME_ZEROS=1, blank every magnitude position above the most-significant nonzero nibble; position 0 is always shown, so a zero value shows "0".
REQ-020 SHALL, when SUPRIME_ZEROS=0, show all magnitude nibbles.
REQ-021 SHALL, when Carregar=1 at an edge, capture Valor and Negativo into a pending buffer, set the pending flag, and drive Pronto=0 from the next cycle.
REQ-022 SHALL copy the pending buffer to the committed register on a frame wrap while pending, then clear the pending flag, so the display never tears mid-frame.
REQ-023 SHALL keep only the latest of several loads made before a frame wrap (last wins).
REQ-024 SHALL, when Carregar coincides with a frame wrap, commit the old pending content, capture the new values into pending, and keep the pending flag set.
REQ-025 SHALL ignore Valor and Negativo while Carregar=0.
REQ-026 SHALL derive Pronto as the inverse of the pending flag.

Reset
REQ-027 SHALL, while Reset=1 at an edge, set prescaler=0, index=0, pending and committed buffers=0, pending flag=0, Hex=7F, Anodo=all ones, Pronto=1.
REQ-028 SHALL give Reset priority over Carregar, and any pending load is discarded.
REQ-029 SHALL, on the first edge after Reset is released, start the prescaler from 0 with digit 0 selected; the first tick follows after DIV_VARREDURA clocks.

Structure
REQ-030 SHALL place the segment constants (digits 0..F, minus, blank) in a shared package, display_pkg, reused by all display blocks.
REQ-031 SHALL instantiate one combinational sub-module, decod_hex7 (4-bit nibble in, 7-bit active-low segments out), for magnitude digits.
REQ-032 SHALL keep the prescaler, index, load buffering and output registers in display_mux.

Verification (DIGITOS=4, DIV_VARREDURA=4 unless stated)
REQ-033 SHALL verify reset: Reset held 2 cycles -> Hex=7F, Anodo=1111, Pronto=1; after release, the first tick occurs on the 4th clock.
REQ-034 SHALL verify display of a positive value: load Valor=3A5, Negativo=0, wait for commit -> positions 0..3 show 12, 08, 30, 7F, with Anodo cycling 1110, 1101, 1011, 0111.
REQ-035 SHALL verify sign and blanking: Valor=00F, Negativo=1 -> positions 0..3 show 0E, 7F, 7F, 3F; with SUPRIME_ZEROS=0 -> 0E, 40, 40, 3F; Valor=000 -> position 0 shows 40.
REQ-036 SHALL verify load buffering: load 111 mid-frame, then 222 before the wrap -> old value persists until the frame wrap, Pronto=0 until the wrap, then 222 shows and Pronto=1; 111 never appears.
REQ-037 SHALL verify timing and dead time: exactly one all-ones Anodo clock after every tick; frame period is 16 clocks.
REQ-038 SHALL verify reset mid-scan: Reset asserted at index 2 with a load pending -> next cycle Hex=7F, Anodo=1111, Pronto=1, the pending value is lost, and the scan restarts at digit 0.
